// File: rtl/adder_chk_pkg.sv
// Shared types and constants for the adder vector checker and its fetch unit.
package adder_chk_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_e;

  // Fetch phase in which each ROM word is on mem_rdata (address was issued one phase earlier).
  localparam logic [1:0] PH_A = 2'd1;
  localparam logic [1:0] PH_B = 2'd2;
  localparam logic [1:0] PH_S = 2'd3;

  localparam int WORDS_PER_VEC = 3;

endpackage

// File: rtl/adder_vec_fetch.sv
// Reads one (a, b, sum) triplet from the synchronous vector ROM and holds it.
module adder_vec_fetch
  import adder_chk_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 7,
  parameter int CNT_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [CNT_W-1:0]  i_vec_idx,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic [DATA_W-1:0] o_a,
  output logic [DATA_W-1:0] o_b,
  output logic [DATA_W-1:0] o_exp,
  output logic              o_fetch_done
);

  logic              r_active;
  logic [1:0]        r_phase;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_exp;

  // NOTE: non-blocking assignments so every register samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active <= 1'b0;
      r_phase  <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_exp    <= '0;
    end else if (i_start) begin
      r_active <= 1'b1;
      r_phase  <= '0;
    end else if (r_active) begin
      r_phase <= r_phase + 2'd1;
      case (r_phase)
        PH_A: r_a <= i_mem_rdata;
        PH_B: r_b <= i_mem_rdata;
        PH_S: begin
          r_exp    <= i_mem_rdata;
          r_active <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Phase 0..2 walk the three words of the vector; phase 3 only collects the last read.
  assign o_mem_addr   = ADDR_W'(i_vec_idx) * ADDR_W'(WORDS_PER_VEC) + ADDR_W'(r_phase);
  assign o_fetch_done = r_active && (r_phase == PH_S);
  assign o_a          = r_a;
  assign o_b          = r_b;
  assign o_exp        = r_exp;

endmodule

// File: rtl/adder_vector_checker.sv
// Plays every ROM vector into the adder, compares the settled sum and keeps a verdict.
module adder_vector_checker
  import adder_chk_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int NUM_VEC = 25,
  parameter int SETTLE  = 1,
  parameter int ADDR_W  = 7,
  parameter int CNT_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b,
  input  logic [DATA_W:0]   y,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  err_count,
  output logic              mismatch,
  output logic [CNT_W-1:0]  vec_idx
);

  localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  state_e            r_state;
  logic [SET_W-1:0]  r_settle_cnt;
  logic [CNT_W-1:0]  r_vec_idx;
  logic [CNT_W-1:0]  r_err_count;
  logic              r_busy;
  logic              r_done;
  logic              r_pass;
  logic              r_mismatch;

  logic              w_fetch_start;
  logic              w_fetch_done;
  logic              w_last;
  logic              w_mismatch;
  logic [DATA_W-1:0] w_exp;

  assign w_last        = (r_vec_idx == CNT_W'(NUM_VEC - 1));
  // A carry out can never match a DATA_W-bit stored sum, so it always counts as a failure.
  assign w_mismatch    = (y != {1'b0, w_exp});
  assign w_fetch_start = ((r_state == S_IDLE || r_state == S_DONE) && start)
                      || (r_state == S_CHECK && !w_last);

  adder_vec_fetch #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) u_fetch (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_start      (w_fetch_start),
    .i_vec_idx    (r_vec_idx),
    .o_mem_addr   (mem_addr),
    .i_mem_rdata  (mem_rdata),
    .o_a          (a),
    .o_b          (b),
    .o_exp        (w_exp),
    .o_fetch_done (w_fetch_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_settle_cnt <= '0;
      r_vec_idx    <= '0;
      r_err_count  <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_mismatch   <= 1'b0;
    end else begin
      r_mismatch <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state     <= S_FETCH;
            r_vec_idx   <= '0;
            r_err_count <= '0;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
          end
        end
        S_FETCH: begin
          if (w_fetch_done) begin
            r_state      <= S_SETTLE;
            r_settle_cnt <= '0;
          end
        end
        S_SETTLE: begin
          // y is judged on the edge that closes the settle window; the pulse shows during CHECK.
          if (r_settle_cnt == SET_W'(SETTLE - 1)) begin
            r_state <= S_CHECK;
            if (w_mismatch) begin
              r_mismatch <= 1'b1;
              if (r_err_count != '1) r_err_count <= r_err_count + CNT_W'(1);
            end
          end else begin
            r_settle_cnt <= r_settle_cnt + SET_W'(1);
          end
        end
        S_CHECK: begin
          if (w_last) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (r_err_count == '0);
          end else begin
            r_state   <= S_FETCH;
            r_vec_idx <= r_vec_idx + CNT_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign err_count = r_err_count;
  assign mismatch  = r_mismatch;
  assign vec_idx   = r_vec_idx;

endmodule

// File: tb/tb_adder_vector_checker.sv
// Drives three checker instances (plain adder, 2-cycle adder with SETTLE=3 and SETTLE=1) against a vector model.
module tb_adder_vector_checker;

  localparam int NV = 25;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] start_v = '0;
  wire  [2:0] busy_v, done_v, pass_v, mis_v;
  wire  [6:0] addr_v [3];
  wire  [7:0] a_v [3];
  wire  [7:0] b_v [3];
  wire  [4:0] err_v [3];
  wire  [4:0] vidx_v [3];

  logic [7:0] rom [0:127];
  int va [NV];
  int vb [NV];
  int vs [NV];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int ST = (g == 1) ? 3 : 1;
    logic [7:0] rd_q;
    logic [8:0] p1_q, p2_q;
    wire  [8:0] y_w;

    always @(posedge clk) begin
      rd_q <= rom[addr_v[g]];
      p1_q <= {1'b0, a_v[g]} + {1'b0, b_v[g]};
      p2_q <= p1_q;
    end
    // Instance 0 sees an ideal adder, the others one whose sum lags its inputs by two clocks.
    assign y_w = (g == 0) ? ({1'b0, a_v[g]} + {1'b0, b_v[g]}) : p2_q;

    adder_vector_checker #(
      .DATA_W (8), .NUM_VEC (NV), .SETTLE (ST), .ADDR_W (7), .CNT_W (5)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start_v[g]),
      .mem_addr  (addr_v[g]),
      .mem_rdata (rd_q),
      .a         (a_v[g]),
      .b         (b_v[g]),
      .y         (y_w),
      .busy      (busy_v[g]),
      .done      (done_v[g]),
      .pass      (pass_v[g]),
      .err_count (err_v[g]),
      .mismatch  (mis_v[g]),
      .vec_idx   (vidx_v[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sync_rom();
    for (int i = 0; i < NV; i++) begin
      rom[3*i]   = 8'(va[i]);
      rom[3*i+1] = 8'(vb[i]);
      rom[3*i+2] = 8'(vs[i]);
    end
  endtask

  // mode 0: random, never carries, all correct; 1: random full range, sum truncated; 2: a=i, b=i, s=2i
  task automatic load(input int mode);
    for (int i = 0; i < NV; i++) begin
      case (mode)
        0: begin
          va[i] = int'($urandom_range(0, 255));
          vb[i] = int'($urandom_range(0, 255 - va[i]));
          vs[i] = va[i] + vb[i];
        end
        1: begin
          va[i] = int'($urandom_range(0, 255));
          vb[i] = int'($urandom_range(0, 255));
          vs[i] = (va[i] + vb[i]) % 256;
        end
        default: begin
          va[i] = i;
          vb[i] = i;
          vs[i] = 2 * i;
        end
      endcase
    end
    sync_rom();
  endtask

  // Failing vectors for an ideal adder: the true 9-bit sum differs from the stored word.
  function automatic void model(output int nfail, output logic [31:0] mask);
    nfail = 0;
    mask  = '0;
    for (int i = 0; i < NV; i++)
      if (va[i] + vb[i] != vs[i]) begin
        nfail++;
        mask[i] = 1'b1;
      end
  endfunction

  function automatic int sat(input int n);
    return (n > 31) ? 31 : n;
  endfunction

  task automatic kick(input int k);
    @(negedge clk);
    start_v[k] = 1'b1;
    @(posedge clk);
    #1 start_v[k] = 1'b0;
  endtask

  task automatic run(input int k, output int cycles, output int pulses, output logic [31:0] mask);
    kick(k);
    cycles = 0;
    pulses = 0;
    mask   = '0;
    while (!done_v[k] && cycles < 1000) begin
      if (mis_v[k]) begin
        pulses++;
        mask[vidx_v[k]] = 1'b1;
      end
      @(posedge clk);
      #1 cycles++;
    end
  endtask

  task automatic check_zero(input string tag, input int k);
    check({tag, "_busy"}, 32'(busy_v[k]), 0);
    check({tag, "_done"}, 32'(done_v[k]), 0);
    check({tag, "_pass"}, 32'(pass_v[k]), 0);
    check({tag, "_mismatch"}, 32'(mis_v[k]), 0);
    check({tag, "_err"}, 32'(err_v[k]), 0);
    check({tag, "_vidx"}, 32'(vidx_v[k]), 0);
    check({tag, "_addr"}, 32'(addr_v[k]), 0);
    check({tag, "_a"}, 32'(a_v[k]), 0);
    check({tag, "_b"}, 32'(b_v[k]), 0);
  endtask

  initial begin
    int nf, cyc, pulses, bprev;
    logic [31:0] em, mask;

    for (int i = 0; i < 128; i++) rom[i] = 8'h00;

    #23 check_zero("reset", 0);
    @(negedge clk) rst_n = 1'b1;

    // All-correct random set: full-length run, clean verdict, last vector held.
    load(0);
    model(nf, em);
    run(0, cyc, pulses, mask);
    check("good_cycles", cyc, 150);
    check("good_done", 32'(done_v[0]), 1);
    check("good_busy", 32'(busy_v[0]), 0);
    check("good_pass", 32'(pass_v[0]), 1);
    check("good_err", 32'(err_v[0]), 0);
    check("good_pulses", pulses, 0);
    check("good_a_last", 32'(a_v[0]), 32'(va[NV-1]));
    check("good_b_last", 32'(b_v[0]), 32'(vb[NV-1]));

    // Corrupted sums at 3, 17 and one random index.
    load(0);
    vs[3]  = (vs[3] + 1) % 256;
    vs[17] = (vs[17] + 1) % 256;
    begin
      int r = int'($urandom_range(0, NV - 1));
      vs[r] = (vs[r] + 1) % 256;
    end
    sync_rom();
    model(nf, em);
    run(0, cyc, pulses, mask);
    check("corrupt_mask", mask, em);
    check("corrupt_pulses", pulses, nf);
    check("corrupt_err", 32'(err_v[0]), 32'(sat(nf)));
    check("corrupt_pass", 32'(pass_v[0]), 0);

    // Carry-out vector with truncated stored sum.
    load(0);
    va[5] = 255;
    vb[5] = 1;
    vs[5] = 0;
    sync_rom();
    model(nf, em);
    run(0, cyc, pulses, mask);
    check("carry_err", 32'(err_v[0]), 1);
    check("carry_mask", mask, em);
    check("carry_pass", 32'(pass_v[0]), 0);

    // Full-range random operands: every carry is a failure.
    load(1);
    model(nf, em);
    run(0, cyc, pulses, mask);
    check("rand_mask", mask, em);
    check("rand_err", 32'(err_v[0]), 32'(sat(nf)));
    check("rand_pass", 32'(pass_v[0]), 32'(nf == 0));

    // Reset at vec_idx 10 aborts the run, then a fresh start runs the whole set.
    load(0);
    vs[2] = (vs[2] + 1) % 256;
    sync_rom();
    kick(0);
    cyc = 0;
    while (vidx_v[0] != 5'd10 && cyc < 200) begin
      @(posedge clk);
      #1 cyc++;
    end
    check("abort_reach_idx10", 32'(vidx_v[0]), 10);
    check("abort_err_before", 32'(err_v[0]), 1);
    rst_n = 1'b0;
    #1 check_zero("abort", 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1 check("abort_idle_busy", 32'(busy_v[0]), 0);
    run(0, cyc, pulses, mask);
    check("abort_rerun_cycles", cyc, 150);
    check("abort_rerun_err", 32'(err_v[0]), 1);
    check("abort_rerun_mask", mask, 32'h4);

    // Starts mid-run and on the DONE-entry edge are ignored; one edge later restarts.
    kick(0);
    repeat (39) @(posedge clk);
    #1 start_v[0] = 1'b1;
    @(posedge clk);
    #1 start_v[0] = 1'b0;
    check("ign_mid_busy", 32'(busy_v[0]), 1);
    check("ign_mid_vidx", 32'(vidx_v[0]), 6);
    repeat (109) @(posedge clk);
    #1 start_v[0] = 1'b1;
    @(posedge clk);
    #1 start_v[0] = 1'b0;
    check("ign_done_done", 32'(done_v[0]), 1);
    check("ign_done_busy", 32'(busy_v[0]), 0);
    check("ign_done_err", 32'(err_v[0]), 1);
    start_v[0] = 1'b1;
    @(posedge clk);
    #1 start_v[0] = 1'b0;
    check("restart_busy", 32'(busy_v[0]), 1);
    check("restart_done", 32'(done_v[0]), 0);
    check("restart_err", 32'(err_v[0]), 0);
    check("restart_vidx", 32'(vidx_v[0]), 0);
    cyc = 0;
    while (!done_v[0] && cyc < 1000) begin
      @(posedge clk);
      #1 cyc++;
    end
    check("restart_cycles", cyc, 150);
    check("restart_final_err", 32'(err_v[0]), 1);

    // Slow adder with a wide enough settle window: every correct vector passes.
    load(0);
    run(1, cyc, pulses, mask);
    check("slow3_cycles", cyc, NV * 8);
    check("slow3_pass", 32'(pass_v[1]), 1);
    check("slow3_err", 32'(err_v[1]), 0);

    // Same slow adder, one-cycle window: the sum still reflects the previous b.
    load(2);
    nf = 0;
    bprev = 0;
    for (int i = 0; i < NV; i++) begin
      if (va[i] + bprev != vs[i]) nf++;
      bprev = vb[i];
    end
    run(2, cyc, pulses, mask);
    check("slow1_cycles", cyc, 150);
    check("slow1_err", 32'(err_v[2]), 32'(sat(nf)));
    check("slow1_pulses", pulses, nf);
    check("slow1_pass", 32'(pass_v[2]), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
